custom_master_slave: RTL and testbench
======================================

// Module: custom_master_slave
// PURPOSE
//  Register-programmed transfer sequencer with an Avalon-MM-style slave port.
//  Software writes a direction, a base address and a transfer count; writing the count launches a burst.
//  Per transfer the block emits an address phase then a data phase on the rdwr_* / n_action strobe
//  interface, which drives an external memory/bus bridge.
// PARAMETERS
//  ADDR_W    32  width of rdwr_address and of the BASE register
//  DATA_W    32  width of slave_writedata
//  ADDR_STEP 4   byte increment of rdwr_address between transfers
// PORTS
//  clk              in   1       rising-edge clock, the only clock
//  reset_n          in   1       synchronous, active-high reset (1 = reset)
//  slave_write      in   1       slave write strobe, qualified by slave_chipselect
//  slave_chipselect in   1       slave select
//  slave_address    in   3       word address of the register
//  slave_writedata  in   DATA_W  write data
//  rdwr_cntl        out  1       transfer direction: 0 = read, 1 = write
//  n_action         out  1       active-low transfer strobe
//  add_data_sel     out  1       1 = address phase, 0 = data phase/idle
//  rdwr_address     out  ADDR_W  current transfer address
// BEHAVIOUR
//  Register map; a register is written when slave_write & slave_chipselect at a rising clk edge:
//   0 CTRL  : bit0 = direction; bits 31:1 are ignored.
//   1 BASE  : start address, full ADDR_W.
//   2 DATA  : scratch word, stored only.
//   3 COUNT : transfer count; a write with a nonzero value while idle starts a burst.
//   4-7     : writes are ignored.
//  While busy (state != IDLE), all slave writes are ignored, including COUNT.
//  A write to COUNT with value 0 is stored but no burst starts.
//  Reset: all registers are 0 and the state is IDLE.
//   Outputs in reset: rdwr_cntl = 0, n_action = 1, add_data_sel = 0, rdwr_address = 0.
//   Reset asserted mid-burst aborts it on the next edge.
//  FSM: IDLE -> ADDR -> DATA -> NEXT -> (ADDR | IDLE); all outputs are registered.
//   IDLE: n_action = 1, add_data_sel = 0. rdwr_address holds its last value.
//   IDLE + launch write: on the next edge go to ADDR with idx = 0.
//    On that edge rdwr_address <= BASE and rdwr_cntl <= CTRL[0].
//   ADDR: n_action = 0, add_data_sel = 1.
//   DATA: n_action = 0, add_data_sel = 0.
//   NEXT: n_action = 1 and idx increments.
//    If idx + 1 == COUNT, go to IDLE.
//    Otherwise go to ADDR with rdwr_address += ADDR_STEP.
//  Timing: one transfer is 3 cycles; a burst of N transfers is busy for 3N cycles.
//   The first ADDR cycle is visible 1 cycle after the launching write edge.
//  Address arithmetic is modulo 2^ADDR_W, so a wrap past all-ones is silent.
//  rdwr_cntl is latched at launch; CTRL writes mid-burst are ignored anyway.
// CONFIGURATION
//  CUSTOM_MASTER_SLAVE_READBACK_EN
//   Defined: adds input slave_read (1) and output slave_readdata (DATA_W).
//    A read with chipselect returns regs 0-3; address 4 returns STATUS {30'b0, done, busy}.
//    Addresses 5-7 read 0. Read latency is 1 cycle (registered).
//    done is sticky: set when a burst ends, cleared by the next launch or by reset.
//   Undefined: neither port exists and there is no STATUS logic.
// TESTING
//  - Reset held 2 cycles -> n_action = 1, add_data_sel = 0, rdwr_cntl = 0, rdwr_address = 0.
//  - CTRL = 0, BASE = 584, DATA = 0, COUNT = 22 -> 22 read transfers, rdwr_cntl = 0,
//    addresses 584, 588, ... 668. Busy for 66 cycles, then IDLE with n_action = 1.
//  - CTRL = 1, BASE = 0x100, COUNT = 2 -> ADDR/DATA/NEXT at 0x100 then 0x104, rdwr_cntl = 1.
//  - COUNT = 0, or writes with chipselect = 0 -> no n_action pulse and no register change.
//  - Writes to BASE and COUNT mid-burst -> ignored; the burst finishes with the original values.
//  - BASE = 0xFFFFFFFC, COUNT = 2 -> addresses 0xFFFFFFFC then 0x00000000.
//    Reset asserted mid-burst -> IDLE on the next edge.

Source files
------------

// File: rtl/custom_master_slave.sv
// custom_master_slave: register-programmed transfer sequencer behind an
// Avalon-MM-style slave port. A nonzero COUNT write while idle launches a
// burst of ADDR/DATA/NEXT triples on the rdwr_* / n_action interface.
// Optional readback port and STATUS register: CUSTOM_MASTER_SLAVE_READBACK_EN.
module custom_master_slave #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              reset_n,          // active-high synchronous reset
  input  logic              slave_write,
  input  logic              slave_chipselect,
  input  logic [2:0]        slave_address,
  input  logic [DATA_W-1:0] slave_writedata,
`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
  input  logic              slave_read,
  output logic [DATA_W-1:0] slave_readdata,
`endif
  output logic              rdwr_cntl,
  output logic              n_action,
  output logic              add_data_sel,
  output logic [ADDR_W-1:0] rdwr_address
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_NEXT} state_t;

  state_t              r_state;
  logic                r_ctrl;
  logic [ADDR_W-1:0]   r_base;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_count;
  logic [DATA_W-1:0]   r_idx;
  logic                r_rdwr_cntl;
  logic                r_n_action;
  logic                r_add_data_sel;
  logic [ADDR_W-1:0]   r_rdwr_address;

  logic w_wr;
  logic w_idle;
  logic w_launch;

  assign w_wr     = slave_write & slave_chipselect;
  assign w_idle   = (r_state == ST_IDLE);
  // Slave writes only land while idle; a nonzero COUNT write is the launch.
  assign w_launch = w_idle & w_wr & (slave_address == 3'd3) & (|slave_writedata);

  assign rdwr_cntl    = r_rdwr_cntl;
  assign n_action     = r_n_action;
  assign add_data_sel = r_add_data_sel;
  assign rdwr_address = r_rdwr_address;

  // Register file: writable only in IDLE, addresses 4-7 are ignored.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_ctrl  <= 1'b0;
      r_base  <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else if (w_idle && w_wr) begin
      case (slave_address)
        3'd0:    r_ctrl  <= slave_writedata[0];
        3'd1:    r_base  <= ADDR_W'(slave_writedata);
        3'd2:    r_data  <= slave_writedata;
        3'd3:    r_count <= slave_writedata;
        default: ;
      endcase
    end
  end

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_rdwr_cntl    <= 1'b0;
      r_n_action     <= 1'b1;
      r_add_data_sel <= 1'b0;
      r_rdwr_address <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_n_action     <= 1'b1;
          r_add_data_sel <= 1'b0;
          if (w_launch) begin
            r_state        <= ST_ADDR;
            r_idx          <= '0;
            r_rdwr_address <= r_base;
            r_rdwr_cntl    <= r_ctrl;
            r_n_action     <= 1'b0;
            r_add_data_sel <= 1'b1;
          end
        end
        ST_ADDR: begin
          r_state        <= ST_DATA;
          r_n_action     <= 1'b0;
          r_add_data_sel <= 1'b0;
        end
        ST_DATA: begin
          r_state        <= ST_NEXT;
          r_n_action     <= 1'b1;
          r_add_data_sel <= 1'b0;
        end
        ST_NEXT: begin
          r_idx <= r_idx + DATA_W'(1);
          if (r_idx + DATA_W'(1) == r_count) begin
            r_state        <= ST_IDLE;
            r_n_action     <= 1'b1;
            r_add_data_sel <= 1'b0;
          end else begin
            // Wraps modulo 2^ADDR_W with no flag.
            r_state        <= ST_ADDR;
            r_rdwr_address <= r_rdwr_address + ADDR_W'(ADDR_STEP);
            r_n_action     <= 1'b0;
            r_add_data_sel <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
  logic              r_done;
  logic [DATA_W-1:0] r_readdata;

  assign slave_readdata = r_readdata;

  // Sticky done: set as a burst retires, cleared by the next launch.
  always_ff @(posedge clk) begin
    if (reset_n)
      r_done <= 1'b0;
    else if (w_launch)
      r_done <= 1'b0;
    else if (r_state == ST_NEXT && (r_idx + DATA_W'(1) == r_count))
      r_done <= 1'b1;
  end

  // Registered readback, one cycle latency.
  always_ff @(posedge clk) begin
    if (reset_n)
      r_readdata <= '0;
    else if (slave_read && slave_chipselect) begin
      case (slave_address)
        3'd0:    r_readdata <= DATA_W'(r_ctrl);
        3'd1:    r_readdata <= DATA_W'(r_base);
        3'd2:    r_readdata <= r_data;
        3'd3:    r_readdata <= r_count;
        3'd4:    r_readdata <= DATA_W'({r_done, ~w_idle});
        default: r_readdata <= '0;
      endcase
    end
  end
`else
  // DATA is a write-only scratch word when readback is absent.
  logic w_unused_data;
  assign w_unused_data = ^r_data;
`endif

endmodule

// File: tb/tb_custom_master_slave.sv
// Bench for custom_master_slave (default build, no readback port).
module tb_custom_master_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        slave_write;
  logic        slave_chipselect;
  logic [2:0]  slave_address;
  logic [31:0] slave_writedata;
  logic        rdwr_cntl;
  logic        n_action;
  logic        add_data_sel;
  logic [31:0] rdwr_address;

  custom_master_slave dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .slave_write      (slave_write),
    .slave_chipselect (slave_chipselect),
    .slave_address    (slave_address),
    .slave_writedata  (slave_writedata),
    .rdwr_cntl        (rdwr_cntl),
    .n_action         (n_action),
    .add_data_sel     (add_data_sel),
    .rdwr_address     (rdwr_address)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cntl;
    logic [31:0] addr;
  } sb_t;

  typedef struct {
    logic        ctrl;
    logic [31:0] base;
    logic [31:0] data;
    logic [31:0] count;
    logic        wr_cfg;     // write CTRL/BASE/DATA before COUNT
    logic        disturb;    // attempt CTRL/BASE/COUNT writes mid-burst
    int          exp_cycles; // expected busy cycles
    logic [31:0] exp_last;   // expected rdwr_address once idle again
  } vec_t;

  sb_t         sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic        m_ctrl = 1'b0;
  logic [31:0] m_base = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  // Scoreboard consumer: every address phase must match the next expected transfer.
  always @(negedge clk) begin
    if (!reset_n && n_action === 1'b0 && add_data_sel === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_addr_phase: got addr %h with nothing expected", rdwr_address);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("addr_phase_address", rdwr_address, e.addr);
        chk("addr_phase_cntl", {31'b0, rdwr_cntl}, {31'b0, e.cntl});
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic cs);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1; slave_chipselect = cs;
    @(posedge clk);
    #1 slave_write = 1'b0; slave_chipselect = 1'b0;
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk(name, {31'b0, n_action}, 32'd1);
    end
  endtask

  task automatic run_burst(input vec_t v);
    if (v.wr_cfg) begin
      wr(3'd0, {31'b0, v.ctrl}, 1'b1);
      wr(3'd1, v.base, 1'b1);
      wr(3'd2, v.data, 1'b1);
      m_ctrl = v.ctrl;
      m_base = v.base;
    end
    for (int i = 0; i < int'(v.count); i++) begin
      sb_t e;
      e.cntl = m_ctrl;
      e.addr = m_base + 32'(i * 4);
      sb_q.push_back(e);
    end
    wr(3'd3, v.count, 1'b1);
    for (int k = 0; k < v.exp_cycles; k++) begin
      @(negedge clk);
      chk("phase_sel", {31'b0, add_data_sel}, {31'b0, (k % 3) == 0});
      chk("phase_n_action", {31'b0, n_action}, {31'b0, (k % 3) == 2});
      if (v.disturb) begin
        slave_write = (k < 3); slave_chipselect = (k < 3);
        case (k)
          0: begin slave_address = 3'd1; slave_writedata = 32'hDEAD0000; end
          1: begin slave_address = 3'd3; slave_writedata = 32'd7; end
          2: begin slave_address = 3'd0; slave_writedata = {31'b0, ~v.ctrl}; end
          default: ;
        endcase
      end
    end
    slave_write = 1'b0; slave_chipselect = 1'b0;
    @(negedge clk);
    chk("idle_n_action", {31'b0, n_action}, 32'd1);
    chk("idle_sel", {31'b0, add_data_sel}, 32'd0);
    chk("idle_addr_hold", rdwr_address, v.exp_last);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vec_t v;
    vecs[0] = '{1'b0, 32'd584,      32'h0,      32'd22, 1'b1, 1'b0, 66, 32'd668};
    vecs[1] = '{1'b1, 32'h100,      32'hA5A5,   32'd2,  1'b1, 1'b0, 6,  32'h104};
    vecs[2] = '{1'b1, 32'hFFFFFFFC, 32'h1,      32'd2,  1'b1, 1'b0, 6,  32'h0};
    vecs[3] = '{1'b0, 32'h40,       32'h2,      32'd3,  1'b1, 1'b1, 9,  32'h48};
    vecs[4] = '{1'b1, 32'hFFFF0000, 32'h3,      32'd1,  1'b0, 1'b0, 3,  32'h40};

    reset_n = 1'b1; slave_write = 1'b0; slave_chipselect = 1'b0;
    slave_address = 3'd0; slave_writedata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_n_action", {31'b0, n_action}, 32'd1);
    chk("rst_sel", {31'b0, add_data_sel}, 32'd0);
    chk("rst_cntl", {31'b0, rdwr_cntl}, 32'd0);
    chk("rst_addr", rdwr_address, 32'd0);
    reset_n = 1'b0;

    for (int i = 0; i < 5; i++) run_burst(vecs[i]);

    // Writes without chipselect change nothing and launch nothing.
    wr(3'd1, 32'h500, 1'b0);
    wr(3'd3, 32'd5, 1'b0);
    watch_quiet("cs0_no_pulse", 6);
    // COUNT = 0 is stored but does not launch.
    wr(3'd3, 32'd0, 1'b1);
    watch_quiet("count0_no_pulse", 6);
    v = '{1'b0, 32'h0, 32'h0, 32'd1, 1'b0, 1'b0, 3, 32'h40};
    run_burst(v);

    // Reset in the middle of a burst.
    wr(3'd0, 32'd1, 1'b1);
    wr(3'd1, 32'h2000, 1'b1);
    for (int i = 0; i < 4; i++) sb_q.push_back('{1'b1, 32'h2000 + 32'(i * 4)});
    wr(3'd3, 32'd4, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk("pre_reset_progress", 32'(sb_q.size()), 32'd2);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_n_action", {31'b0, n_action}, 32'd1);
    chk("midrst_sel", {31'b0, add_data_sel}, 32'd0);
    chk("midrst_cntl", {31'b0, rdwr_cntl}, 32'd0);
    chk("midrst_addr", rdwr_address, 32'd0);
    reset_n = 1'b0;
    sb_q.delete();
    watch_quiet("post_rst_quiet", 4);
    m_ctrl = 1'b0; m_base = 32'h0;
    // Registers are back to 0: a COUNT-only launch reads at 0 with cntl 0.
    v = '{1'b0, 32'h0, 32'h0, 32'd1, 1'b0, 1'b0, 3, 32'h0};
    run_burst(v);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
